// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave receive path.
//   - rx_state_t and its state constants for the receive FSM
//   - I2C_ADDR_W / I2C_BYTE_W bus widths, I2C_CNT_W bit-counter width
//   - SDA_ACK / SDA_NACK: the Sda_oe level driven in the ninth SCL period
//   - addr_match(): compares the 7 address bits of a byte with an address
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;
  localparam int I2C_CNT_W  = 4;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_SHIFT     = 3'd1;
  localparam rx_state_t ST_ACK_WAIT  = 3'd2;
  localparam rx_state_t ST_ACK_DRIVE = 3'd3;
  localparam rx_state_t ST_IGNORE    = 3'd4;

  // Sda_oe = 1 pulls SDA low, which is an ACK on the bus.
  localparam logic SDA_ACK  = 1'b1;
  localparam logic SDA_NACK = 1'b0;

  // Address occupies bits [7:1] of the first byte; bit 0 is R/W.
  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] byte_v,
                                      input logic [I2C_ADDR_W-1:0] addr_v);
    return (byte_v[I2C_BYTE_W-1:1] == addr_v);
  endfunction

endpackage

// File: rtl/i2c_rx_shifter.sv
// ---------------------------------------------------------------------------
// i2c_rx_shifter
// 8-bit MSB-first shift register with a 4-bit received-bit counter.
// Ports:
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   clr_i        clear counter and shift register (priority over shift_i)
//   shift_i      shift bit_i in and increment the counter
//   bit_i        sampled SDA level
//   byte_o       the byte as it will be once bit_i is shifted in
//   byte_done_o  shift_i is the 8th bit of the current byte
// ---------------------------------------------------------------------------
module i2c_rx_shifter
  import i2c_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic                  bit_i,
  output logic [I2C_BYTE_W-1:0] byte_o,
  output logic                  byte_done_o
);

  logic [I2C_BYTE_W-1:0] shreg_q, shreg_d;
  logic [I2C_CNT_W-1:0]  cnt_q, cnt_d;

  // Look-ahead byte so the top can capture the full byte on the 8th strobe
  // without waiting a cycle for the register to settle.
  assign byte_o      = {shreg_q[I2C_BYTE_W-2:0], bit_i};
  assign byte_done_o = shift_i && (cnt_q == 4'd7);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_i) begin
      shreg_d = byte_o;
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_rx_sipo_slave.sv
// ---------------------------------------------------------------------------
// i2c_rx_sipo_slave
// Receive stage of the I2C slave: samples SDA on SCL rising strobes, builds
// MSB-first bytes, drives ACK/NACK in the ninth SCL period and presents each
// byte to the byte logic through a valid/ack handshake.
// Ports:
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   start_i       START / repeated START pulse
//   stop_i        STOP pulse
//   scl_rise_i    SCL rising-edge strobe (sample sda_in_i)
//   scl_fall_i    SCL falling-edge strobe (update sda_oe_o)
//   sda_in_i      synchronised SDA level
//   data_o        last completed byte
//   data_valid_o  data_o holds an unconsumed byte
//   data_ack_i    consumer pulse clearing data_valid_o
//   is_addr_o     data_o is the first byte after START
//   sda_oe_o      1 = pull SDA low
//   overrun_o     sticky: byte completed while data_valid_o was high
//   busy_o        FSM not idle
// Build option: define I2C_RX_ADDR_MATCH_EN to compare the address byte
// against SLAVE_ADDR and NACK/ignore transfers for other slaves.
// ---------------------------------------------------------------------------
module i2c_rx_sipo_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h2A
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  scl_rise_i,
  input  logic                  scl_fall_i,
  input  logic                  sda_in_i,
  output logic [I2C_BYTE_W-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ack_i,
  output logic                  is_addr_o,
  output logic                  sda_oe_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

`ifdef I2C_RX_ADDR_MATCH_EN
  localparam bit ADDR_MATCH_EN = 1'b1;
`else
  localparam bit ADDR_MATCH_EN = 1'b0;
`endif

  rx_state_t             state_q, state_d;
  logic [I2C_BYTE_W-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  is_addr_q, is_addr_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;
  logic                  first_q, first_d;     // next byte is the address byte
  logic                  ack_q, ack_d;         // decision for the pending ninth bit
  logic                  byte_addr_q, byte_addr_d; // pending byte was an address

  logic                  sh_clr, sh_shift;
  logic [I2C_BYTE_W-1:0] sh_byte;
  logic                  sh_done;
  logic                  rise_eff, fall_eff;
  logic                  addr_ok;

  i2c_rx_shifter u_shifter (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (sh_clr),
    .shift_i     (sh_shift),
    .bit_i       (sda_in_i),
    .byte_o      (sh_byte),
    .byte_done_o (sh_done)
  );

  // A coincident rise/fall pair can only be resolved one way: keep the rise.
  assign rise_eff = scl_rise_i;
  assign fall_eff = scl_fall_i && !scl_rise_i;

  // Data bytes always pass; address bytes pass unless matching is built in.
  assign addr_ok = !first_q || !ADDR_MATCH_EN || addr_match(sh_byte, SLAVE_ADDR);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = valid_q;
    is_addr_d   = is_addr_q;
    sda_oe_d    = sda_oe_q;
    overrun_d   = overrun_q;
    first_d     = first_q;
    ack_d       = ack_q;
    byte_addr_d = byte_addr_q;
    sh_clr      = 1'b0;
    sh_shift    = 1'b0;

    // Consumer handshake; a byte completing this cycle re-sets valid below.
    if (data_ack_i) begin
      valid_d = 1'b0;
    end

    if (start_i) begin
      // START and repeated START both restart byte assembly; only a fresh
      // transaction out of IDLE clears the sticky overrun.
      if (state_q == ST_IDLE) begin
        overrun_d = 1'b0;
      end
      state_d  = ST_SHIFT;
      first_d  = 1'b1;
      sda_oe_d = SDA_NACK;
      sh_clr   = 1'b1;
    end else if (stop_i) begin
      state_d  = ST_IDLE;
      sda_oe_d = SDA_NACK;
      sh_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (rise_eff) begin
            sh_shift = 1'b1;
            if (sh_done) begin
              state_d     = ST_ACK_WAIT;
              first_d     = 1'b0;
              byte_addr_d = first_q;
              if (valid_q && !data_ack_i) begin
                // Previous byte still unread: keep it, flag and refuse.
                overrun_d = 1'b1;
                ack_d     = SDA_NACK;
              end else begin
                data_d    = sh_byte;
                is_addr_d = first_q;
                if (addr_ok) begin
                  valid_d = 1'b1;
                  ack_d   = SDA_ACK;
                end else begin
                  ack_d   = SDA_NACK;
                end
              end
            end
          end
        end
        ST_ACK_WAIT: begin
          if (fall_eff) begin
            sda_oe_d = ack_q;
            state_d  = ST_ACK_DRIVE;
          end
        end
        ST_ACK_DRIVE: begin
          // The ninth rise is the master sampling our ACK; only its
          // following fall ends the acknowledge period.
          if (fall_eff) begin
            sda_oe_d = SDA_NACK;
            sh_clr   = 1'b1;
            if (ADDR_MATCH_EN && byte_addr_q && (ack_q == SDA_NACK)) begin
              state_d = ST_IGNORE;
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end
        default: begin
          // ST_IDLE and ST_IGNORE wait for START/STOP only.
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      valid_q     <= 1'b0;
      is_addr_q   <= 1'b0;
      sda_oe_q    <= SDA_NACK;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      first_q     <= 1'b0;
      ack_q       <= SDA_NACK;
      byte_addr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      is_addr_q   <= is_addr_d;
      sda_oe_q    <= sda_oe_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      first_q     <= first_d;
      ack_q       <= ack_d;
      byte_addr_q <= byte_addr_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign is_addr_o    = is_addr_q;
  assign sda_oe_o     = sda_oe_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy_q;

endmodule
